// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer: state encoding and index sizing.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_REL  = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  // Index register width: enough to address every domain, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_seq_cnt.sv
// Loadable down-counter shared by the hold window and the per-domain release gaps.
module reset_seq_cnt #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all downstream reset domains low for a fixed window, then releases them in
// index order with programmable gaps; software requests re-run the sequence and are acked.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int DLY      = 1,
  parameter int N_DOM    = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   sw_rst_req_i,
  input  logic [N_DOM*CNT_W-1:0] dom_delay_i,
  output logic [N_DOM-1:0]       dom_rst_n_o,
  output logic                   seq_busy_o,
  output logic                   seq_done_o,
  output logic                   sw_rst_ack_o,
  output seq_state_e             seq_state_o
);

  localparam int               IDX_W    = idx_width(N_DOM);
  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DOM - 1);

  // DLY is accepted for drop-in compatibility; registers update with zero delay so
  // synthesis and simulation agree.
  if (DLY < 0) begin : g_bad_dly
    $error("DLY must be non-negative");
  end
  if (N_DOM < 1) begin : g_bad_ndom
    $error("N_DOM must be at least 1");
  end
  if ((HOLD_CYC < 1) || (longint'(HOLD_CYC) > (64'd1 << CNT_W))) begin : g_bad_hold
    $error("HOLD_CYC must lie in 1 .. 2**CNT_W");
  end

  seq_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             sw_flag;
  logic             last_dom;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic [CNT_W-1:0] delay [N_DOM];

  always_comb begin
    for (int k = 0; k < N_DOM; k++) begin
      delay[k] = dom_delay_i[k*CNT_W +: CNT_W];
    end
  end

  assign idx_next = idx + 1'b1;
  assign last_dom = (idx == LAST_IDX);

  // Counter control: delays are sampled only at the moment they are loaded.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    case (state)
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = delay[0];
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_REL: begin
        if (cnt_zero) begin
          if (!last_dom) begin
            cnt_load     = 1'b1;
            cnt_load_val = delay[idx_next];
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (sw_rst_req_i) begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_VAL;
        end
      end
      default: begin
        cnt_load     = 1'b1;
        cnt_load_val = HOLD_VAL;
      end
    endcase
  end

  reset_seq_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (HOLD_VAL)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_HOLD;
      idx          <= '0;
      sw_flag      <= 1'b0;
      dom_rst_n_o  <= '0;
      seq_busy_o   <= 1'b1;
      seq_done_o   <= 1'b0;
      sw_rst_ack_o <= 1'b0;
    end else begin
      sw_rst_ack_o <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (cnt_zero) begin
            state <= ST_REL;
            idx   <= '0;
          end
        end
        ST_REL: begin
          if (cnt_zero) begin
            dom_rst_n_o[idx] <= 1'b1;
            if (last_dom) begin
              state        <= ST_RUN;
              seq_busy_o   <= 1'b0;
              seq_done_o   <= 1'b1;
              sw_rst_ack_o <= sw_flag;
              sw_flag      <= 1'b0;
            end else begin
              idx <= idx_next;
            end
          end
        end
        ST_RUN: begin
          if (sw_rst_req_i) begin
            state       <= ST_HOLD;
            dom_rst_n_o <= '0;
            sw_flag     <= 1'b1;
            seq_busy_o  <= 1'b1;
            seq_done_o  <= 1'b0;
          end
        end
        default: begin
          state       <= ST_HOLD;
          dom_rst_n_o <= '0;
          seq_busy_o  <= 1'b1;
          seq_done_o  <= 1'b0;
        end
      endcase
    end
  end

  assign seq_state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (hold windows 4 and 1) share stimulus and are
// checked every cycle against release edges computed from the timing formula.
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int HA = 4;
  localparam int HB = 1;
  localparam int NO_CHG = 100000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           sw_req = 1'b0;
  logic [N*W-1:0] dly = '0;

  logic [N-1:0] dom_a, dom_b;
  logic         busy_a, busy_b, done_a, done_b, ack_a, ack_b;
  logic [1:0]   st_a, st_b;

  int n_cmp = 0;
  int n_err = 0;
  int d_cur[N];
  int d_new[N];

  always #5 clk = ~clk;

  reset_sequencer #(.DLY(1), .N_DOM(N), .CNT_W(W), .HOLD_CYC(HA)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .sw_rst_req_i(sw_req), .dom_delay_i(dly),
    .dom_rst_n_o(dom_a), .seq_busy_o(busy_a), .seq_done_o(done_a),
    .sw_rst_ack_o(ack_a), .seq_state_o(st_a)
  );

  reset_sequencer #(.DLY(1), .N_DOM(N), .CNT_W(W), .HOLD_CYC(HB)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .sw_rst_req_i(sw_req), .dom_delay_i(dly),
    .dom_rst_n_o(dom_b), .seq_busy_o(busy_b), .seq_done_o(done_b),
    .sw_rst_ack_o(ack_b), .seq_state_o(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int d[N]);
    logic [N*W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(d[k]);
    return v;
  endfunction

  // Release edge of each domain; a delay driven after edge chg is seen by loads at later edges.
  function automatic void calc(input int hold, input int dold[N], input int dnew[N],
                               input int chg, output int e[N]);
    int prev;
    int d;
    prev = hold;
    for (int k = 0; k < N; k++) begin
      d = (prev > chg) ? dnew[k] : dold[k];
      e[k] = prev + d + 1;
      prev = e[k];
    end
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_dom_a"}, 32'(dom_a), 32'd0);
    chk({tag, "_dom_b"}, 32'(dom_b), 32'd0);
    chk({tag, "_busy_a"}, 32'(busy_a), 32'd1);
    chk({tag, "_busy_b"}, 32'(busy_b), 32'd1);
    chk({tag, "_done_a"}, 32'(done_a), 32'd0);
    chk({tag, "_done_b"}, 32'(done_b), 32'd0);
    chk({tag, "_ack_a"}, 32'(ack_a), 32'd0);
    chk({tag, "_ack_b"}, 32'(ack_b), 32'd0);
    chk({tag, "_st_a"}, 32'(st_a), 32'd0);
    chk({tag, "_st_b"}, 32'(st_b), 32'd0);
  endtask

  task automatic check_outs(input int n, input bit sw, input int ea[N], input int eb[N]);
    logic [N-1:0] xa, xb;
    for (int k = 0; k < N; k++) begin
      xa[k] = (n >= ea[k]);
      xb[k] = (n >= eb[k]);
    end
    chk($sformatf("dom_a@%0d", n), 32'(dom_a), 32'(xa));
    chk($sformatf("dom_b@%0d", n), 32'(dom_b), 32'(xb));
    chk($sformatf("busy_a@%0d", n), 32'(busy_a), 32'(n < ea[N-1]));
    chk($sformatf("busy_b@%0d", n), 32'(busy_b), 32'(n < eb[N-1]));
    chk($sformatf("done_a@%0d", n), 32'(done_a), 32'(n >= ea[N-1]));
    chk($sformatf("done_b@%0d", n), 32'(done_b), 32'(n >= eb[N-1]));
    chk($sformatf("ack_a@%0d", n), 32'(ack_a), 32'(sw && (n == ea[N-1])));
    chk($sformatf("ack_b@%0d", n), 32'(ack_b), 32'(sw && (n == eb[N-1])));
  endtask

  // Called one time unit after edge 0 of a sequence; stop_at > 0 ends early at that edge.
  task automatic run_seq(input bit sw, input int chg, input int req_until, input int stop_at);
    int ea[N];
    int eb[N];
    int last;
    calc(HA, d_cur, d_new, chg, ea);
    calc(HB, d_cur, d_new, chg, eb);
    last = ((ea[N-1] > eb[N-1]) ? ea[N-1] : eb[N-1]) + 3;
    if (stop_at > 0) last = stop_at;
    sw_req = (req_until > 0);
    check_outs(0, sw, ea, eb);
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      #1;
      check_outs(n, sw, ea, eb);
      sw_req = (n < req_until);
      if (n == chg) dly = pack(d_new);
    end
    d_cur  = d_new;
    sw_req = 1'b0;
  endtask

  task automatic sw_request();
    sw_req = 1'b1;
    @(posedge clk);
    #1;
    sw_req = 1'b0;
  endtask

  task automatic min_final(output int m);
    int ea[N];
    int eb[N];
    calc(HA, d_cur, d_new, NO_CHG, ea);
    calc(HB, d_cur, d_new, NO_CHG, eb);
    m = (ea[N-1] < eb[N-1]) ? ea[N-1] : eb[N-1];
  endtask

  initial begin
    int mf;
    int chg;
    int req_until;
    int k;

    d_cur = '{2, 0, 3, 1};
    d_new = d_cur;
    dly   = pack(d_cur);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");

    // Power-on sequence
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b0, NO_CHG, 0, 0);
    chk("run_st_a", 32'(st_a), 32'd2);
    chk("run_st_b", 32'(st_b), 32'd2);

    // Software reset
    sw_request();
    run_seq(1'b1, NO_CHG, 0, 0);

    // Mid-sequence reset after domain 1 release, then request held while busy
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rst_a");
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b0, NO_CHG, 0, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_async");
    @(posedge clk);
    #1;
    check_reset("mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    min_final(mf);
    run_seq(1'b0, NO_CHG, mf - 1, 0);

    // Interrupted software sequence must not ack afterwards
    sw_request();
    run_seq(1'b1, NO_CHG, 0, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("sw_intr");
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b0, NO_CHG, 0, 0);

    // Delay change before domain 3 is loaded
    d_new    = d_cur;
    d_new[3] = 5;
    sw_request();
    run_seq(1'b1, 10, 0, 0);

    // All delays zero
    d_cur = '{0, 0, 0, 0};
    d_new = d_cur;
    dly   = pack(d_cur);
    sw_request();
    run_seq(1'b1, NO_CHG, 0, 0);

    // Randomized sequences
    repeat (8) begin
      for (int j = 0; j < N; j++) d_cur[j] = $urandom_range(0, 6);
      d_new = d_cur;
      dly   = pack(d_cur);
      min_final(mf);
      chg = NO_CHG;
      if ($urandom_range(0, 1) == 1) begin
        k        = $urandom_range(0, N - 1);
        d_new[k] = $urandom_range(0, 6);
        chg      = $urandom_range(1, 12);
      end
      req_until = $urandom_range(0, mf - 1);
      sw_request();
      run_seq(1'b1, chg, req_until, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
